// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter for a 32x8 two-lane register file: round-robin idle arbitration, bounded lock, registered issue, fixed-latency read return.
// Build option: define REGFILE_ARB_FIXED_PRIO_EN for fixed A-over-B idle priority instead of round-robin.
module regfile_port_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        lock_a,
  input  logic        lock_b,
  input  logic        we_a,
  input  logic        we_b,
  input  logic [1:0]  lanes_a,
  input  logic [1:0]  lanes_b,
  input  logic [9:0]  addr_a,
  input  logic [9:0]  addr_b,
  input  logic [15:0] wdata_a,
  input  logic [15:0] wdata_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [15:0] rdata,
  output logic        collide,
  output logic [1:0]  rf_wr_en,
  output logic [1:0]  rf_rd_en,
  output logic [9:0]  rf_wr_addr,
  output logic [9:0]  rf_rd_addr,
  output logic [15:0] rf_data_in,
  input  logic [15:0] rf_data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

  state_t      state;
  logic [7:0]  lock_cnt;
  logic        pick_b;
  logic        contend;
  logic        acc_a;
  logic        acc_b;
  logic        accept;
  logic        sel_b;
  logic        sel_we;
  logic        sel_lock;
  logic [1:0]  sel_lanes;
  logic [9:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic [7:0]  next_cnt;
  logic        hit_max;
  logic        rd_pend;
  logic        rd_src;
  logic        coll_pend;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  // Set only by a forced release of A, so a waiting B gets the very next idle grant.
  logic yield_b;
  assign pick_b = yield_b;
`else
  logic rr_ptr;  // 0 = A next on contention, 1 = B next
  assign pick_b = rr_ptr;
`endif

  assign contend = (state == S_IDLE) && req_a && req_b;

  always_comb begin
    // NOTE: defaults first so every path assigns the grants and no latch is inferred.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state)
      S_IDLE: begin
        if (contend) begin
          gnt_a = !pick_b;
          gnt_b = pick_b;
        end else begin
          gnt_a = req_a;
          gnt_b = req_b;
        end
      end
      S_OWN_A: gnt_a = req_a;
      S_OWN_B: gnt_b = req_b;
      default: ;
    endcase
  end

  assign acc_a     = req_a && gnt_a;
  assign acc_b     = req_b && gnt_b;
  assign accept    = acc_a || acc_b;
  assign sel_b     = acc_b;
  assign sel_we    = sel_b ? we_b    : we_a;
  assign sel_lock  = sel_b ? lock_b  : lock_a;
  assign sel_lanes = sel_b ? lanes_b : lanes_a;
  assign sel_addr  = sel_b ? addr_b  : addr_a;
  assign sel_wdata = sel_b ? wdata_b : wdata_a;

  // A locked acceptance from IDLE starts the run at 1; inside ownership it counts on.
  assign next_cnt = (state == S_IDLE) ? 8'd1 : lock_cnt + 8'd1;
  assign hit_max  = sel_lock && (next_cnt == LOCK_LIMIT);

  // Ownership FSM; a dropped request while owning leaves everything untouched.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      lock_cnt <= '0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      yield_b  <= 1'b0;
`else
      rr_ptr   <= 1'b0;
`endif
    end else if (accept) begin
      // NOTE: non-blocking assignments so every update here sees the pre-edge state.
      if (!sel_lock || hit_max) begin
        state    <= S_IDLE;
        lock_cnt <= '0;
      end else begin
        state    <= sel_b ? S_OWN_B : S_OWN_A;
        lock_cnt <= next_cnt;
      end
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      yield_b <= hit_max && !sel_b;
`else
      if (hit_max || contend) rr_ptr <= !sel_b;
`endif
    end
  end

  // Issue stage: register-file controls live for exactly one cycle per accepted transfer.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rf_wr_en   <= '0;
      rf_rd_en   <= '0;
      rf_wr_addr <= '0;
      rf_rd_addr <= '0;
      rf_data_in <= '0;
      rd_pend    <= 1'b0;
      rd_src     <= 1'b0;
      coll_pend  <= 1'b0;
    end else begin
      rf_wr_en   <= '0;
      rf_rd_en   <= '0;
      rf_wr_addr <= '0;
      rf_rd_addr <= '0;
      rf_data_in <= '0;
      rd_pend    <= 1'b0;
      rd_src     <= 1'b0;
      coll_pend  <= 1'b0;
      if (accept) begin
        if (sel_we) begin
          rf_wr_en   <= sel_lanes;
          rf_wr_addr <= sel_addr;
          rf_data_in <= sel_wdata;
          coll_pend  <= (sel_lanes == 2'b11) && (sel_addr[4:0] == sel_addr[9:5]);
        end else begin
          rf_rd_en   <= sel_lanes;
          rf_rd_addr <= sel_addr;
          rd_pend    <= 1'b1;
          rd_src     <= sel_b;
        end
      end
    end
  end

  // Return stage: rf_rd_en still holds the issued lanes here, so disabled lanes are zeroed.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata    <= '0;
      collide  <= 1'b0;
    end else begin
      rvalid_a <= rd_pend && !rd_src;
      rvalid_b <= rd_pend && rd_src;
      collide  <= coll_pend;
      if (rd_pend) begin
        rdata <= {rf_rd_en[1] ? rf_data_out[15:8] : 8'h00,
                  rf_rd_en[0] ? rf_data_out[7:0]  : 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter (default round-robin build) with a behavioural 32x8 two-lane register file.
module tb_regfile_port_arbiter;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        we;
    logic [1:0]  lanes;
    logic [9:0]  addr;
    logic [15:0] wdata;
  } port_t;

  // gnt and rvalid are packed {a, b}; rdata is compared only when an rvalid is expected.
  typedef struct {
    port_t       a;
    port_t       b;
    logic [1:0]  gnt;
    logic [1:0]  wr_en;
    logic [1:0]  rd_en;
    logic [1:0]  rvalid;
    logic [15:0] rdata;
    logic        coll;
  } vec_t;

  localparam port_t IDLE_P = '0;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        req_a, req_b, lock_a, lock_b, we_a, we_b;
  logic [1:0]  lanes_a, lanes_b;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, collide;
  logic [15:0] rdata;
  logic [1:0]  rf_wr_en, rf_rd_en;
  logic [9:0]  rf_wr_addr, rf_rd_addr;
  logic [15:0] rf_data_in;
  logic [15:0] rf_data_out = '0;

  int checks = 0;
  int errors = 0;

  regfile_port_arbiter #(.LOCK_MAX(8)) dut (
    .clock(clock), .nreset(nreset),
    .req_a(req_a), .req_b(req_b), .lock_a(lock_a), .lock_b(lock_b),
    .we_a(we_a), .we_b(we_b), .lanes_a(lanes_a), .lanes_b(lanes_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .collide(collide),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_wr_addr(rf_wr_addr), .rf_rd_addr(rf_rd_addr),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  always #5 clock = ~clock;

  // Register file model: writes on posedge (high lane last, so it wins), read data appears at negedge.
  logic [7:0] mem [32];
  always @(posedge clock) begin
    if (rf_wr_en[0]) mem[rf_wr_addr[4:0]] <= rf_data_in[7:0];
    if (rf_wr_en[1]) mem[rf_wr_addr[9:5]] <= rf_data_in[15:8];
  end
  always @(negedge clock) begin
    rf_data_out <= {mem[rf_rd_addr[9:5]], mem[rf_rd_addr[4:0]]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input port_t a, input port_t b);
    req_a = a.req;  lock_a = a.lock;  we_a = a.we;  lanes_a = a.lanes;  addr_a = a.addr;  wdata_a = a.wdata;
    req_b = b.req;  lock_b = b.lock;  we_b = b.we;  lanes_b = b.lanes;  addr_b = b.addr;  wdata_b = b.wdata;
  endtask

  function automatic port_t pr(input logic lock, input logic we, input logic [1:0] lanes,
                               input logic [9:0] addr, input logic [15:0] wdata);
    port_t p;
    p.req = 1'b1;  p.lock = lock;  p.we = we;  p.lanes = lanes;  p.addr = addr;  p.wdata = wdata;
    return p;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " ctl"}, 32'({rf_wr_en, rf_rd_en, rvalid_a, rvalid_b, collide, rf_wr_addr, rf_rd_addr}), 32'd0);
    check({tag, " data"}, {rdata, rf_data_in}, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int   cnt_a;
    logic got_b;
    int   stray;

    // addr {hi,lo}: {3,2} = 10'h062, {4,4} = 10'h084, {0,4} = 10'h004
    vecs.push_back('{pr(0,1,2'b11,10'h062,16'hBEEF), IDLE_P, 2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{pr(0,0,2'b11,10'h062,16'h0000), IDLE_P, 2'b10, 2'b11, 2'b00, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b11, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b00, 2'b10, 16'hBEEF, 1'b0});
    vecs.push_back('{pr(0,0,2'b01,10'h062,16'h0000), IDLE_P, 2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{pr(0,0,2'b00,10'h062,16'h0000), IDLE_P, 2'b10, 2'b00, 2'b01, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b00, 2'b10, 16'h00EF, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b00, 2'b10, 16'h0000, 1'b0});
    vecs.push_back('{pr(0,1,2'b11,10'h084,16'h1234), IDLE_P, 2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{pr(0,0,2'b01,10'h004,16'h0000), IDLE_P, 2'b10, 2'b11, 2'b00, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b01, 2'b00, 16'h0000, 1'b1});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b00, 2'b10, 16'h0012, 1'b0});
    vecs.push_back('{pr(0,0,2'b11,10'h062,16'h0000), pr(0,0,2'b11,10'h084,16'h0000), 2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{pr(0,0,2'b11,10'h062,16'h0000), pr(0,0,2'b11,10'h084,16'h0000), 2'b01, 2'b00, 2'b11, 2'b00, 16'h0000, 1'b0});
    vecs.push_back('{pr(0,0,2'b11,10'h062,16'h0000), pr(0,0,2'b11,10'h084,16'h0000), 2'b10, 2'b00, 2'b11, 2'b10, 16'hBEEF, 1'b0});
    vecs.push_back('{pr(0,0,2'b11,10'h062,16'h0000), pr(0,0,2'b11,10'h084,16'h0000), 2'b01, 2'b00, 2'b11, 2'b01, 16'h1212, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b11, 2'b10, 16'hBEEF, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b00, 2'b01, 16'h1212, 1'b0});
    vecs.push_back('{IDLE_P, IDLE_P, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0});

    drive(IDLE_P, IDLE_P);
    #1;
    check_reset("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;

    foreach (vecs[i]) begin
      next_cycle();
      drive(vecs[i].a, vecs[i].b);
      @(negedge clock);
      check($sformatf("v%0d gnt", i), 32'({gnt_a, gnt_b}), 32'(vecs[i].gnt));
      check($sformatf("v%0d rf_wr_en", i), 32'(rf_wr_en), 32'(vecs[i].wr_en));
      check($sformatf("v%0d rf_rd_en", i), 32'(rf_rd_en), 32'(vecs[i].rd_en));
      check($sformatf("v%0d rvalid", i), 32'({rvalid_a, rvalid_b}), 32'(vecs[i].rvalid));
      check($sformatf("v%0d collide", i), 32'(collide), 32'(vecs[i].coll));
      if (vecs[i].rvalid != 2'b00)
        check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
    end

    // Bounded lock: A holds lock with B waiting; expect 8 A acceptances, then B.
    next_cycle();
    drive(pr(1,1,2'b00,10'h000,16'h0000), pr(0,0,2'b00,10'h000,16'h0000));
    cnt_a = 0;
    got_b = 1'b0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      if (i != 0) next_cycle();
      @(negedge clock);
      if (gnt_b) got_b = 1'b1;
      else if (gnt_a) cnt_a++;
    end
    check("lock A acceptances", 32'(cnt_a), 32'd8);
    check("lock B granted after release", 32'(got_b), 32'd1);

    // Ownership holds while the owner drops its request.
    next_cycle();
    drive(pr(1,1,2'b00,10'h000,16'h0000), IDLE_P);
    @(negedge clock);
    check("own enter gnt", 32'({gnt_a, gnt_b}), 32'b10);
    next_cycle();
    drive(IDLE_P, pr(0,0,2'b00,10'h000,16'h0000));
    @(negedge clock);
    check("own hold gnt", 32'({gnt_a, gnt_b}), 32'b00);
    next_cycle();
    drive(pr(0,1,2'b00,10'h000,16'h0000), pr(0,0,2'b00,10'h000,16'h0000));
    @(negedge clock);
    check("own unlock gnt", 32'({gnt_a, gnt_b}), 32'b10);
    next_cycle();
    @(negedge clock);
    check("idle rr after unlock", 32'({gnt_a, gnt_b}), 32'b10);

    // Reset between read acceptance and return; pointer currently favours B.
    next_cycle();
    drive(pr(0,0,2'b11,10'h062,16'h0000), IDLE_P);
    @(negedge clock);
    check("pre-reset read gnt", 32'({gnt_a, gnt_b}), 32'b10);
    next_cycle();
    drive(IDLE_P, IDLE_P);
    check("pre-reset rf_rd_en", 32'(rf_rd_en), 32'b11);
    #2;
    nreset = 1'b0;
    #1;
    check_reset("mid reset");
    @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rvalid_a || rvalid_b) stray++;
    end
    check("no rvalid after reset", 32'(stray), 32'd0);
    next_cycle();
    drive(pr(0,0,2'b00,10'h000,16'h0000), pr(0,0,2'b00,10'h000,16'h0000));
    @(negedge clock);
    check("post-reset contention gnt", 32'({gnt_a, gnt_b}), 32'b10);

    next_cycle();
    drive(IDLE_P, IDLE_P);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
